// File: rtl/char_blitter_if.sv
// Request, glyph-ROM and plot-port signals of the glyph blitter.
// The master is the caller side (drives start, returns ROM data, accepts pixels); the slave is the blitter.
interface char_blitter_if #(
  parameter int GLYPH_W  = 10,
  parameter int CODE_W   = 6,
  parameter int ROW_W    = 4,
  parameter int COORD_W  = 8,
  parameter int COLOUR_W = 6
);
  logic                     start;
  logic [CODE_W-1:0]        char_code;
  logic [COORD_W-1:0]       org_x;
  logic [COORD_W-1:0]       org_y;
  logic [COLOUR_W-1:0]      fg_colour;
  logic [COLOUR_W-1:0]      bg_colour;
  logic                     opaque;
  logic                     busy;
  logic                     done;
  logic [CODE_W+ROW_W-1:0]  rom_addr;
  logic [GLYPH_W-1:0]       rom_data;
  logic [COORD_W-1:0]       out_x;
  logic [COORD_W-1:0]       out_y;
  logic [COLOUR_W-1:0]      out_colour;
  logic                     plot;
  logic                     pixel_ready;

  modport master (
    output start, char_code, org_x, org_y, fg_colour, bg_colour, opaque, rom_data, pixel_ready,
    input  busy, done, rom_addr, out_x, out_y, out_colour, plot
  );

  modport slave (
    input  start, char_code, org_x, org_y, fg_colour, bg_colour, opaque, rom_data, pixel_ready,
    output busy, done, rom_addr, out_x, out_y, out_colour, plot
  );
endinterface

// File: rtl/char_blitter.sv
// Glyph renderer: one ROM row fetch per glyph line, one clipped pixel write per cell, 2+GLYPH_W cycles per row.
// Back-pressure: a drawable cell holds plot/out_* stable until pixel_ready; non-drawable cells never wait.
module char_blitter #(
  parameter int GLYPH_W  = 10,
  parameter int GLYPH_H  = 10,
  parameter int CODE_W   = 6,
  parameter int ROW_W    = 4,
  parameter int COORD_W  = 8,
  parameter int COLOUR_W = 6,
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120
) (
  input logic           clock,
  input logic           resetn,
  char_blitter_if.slave bus_if
);
  localparam int COL_W = $clog2(GLYPH_W);
  localparam logic [COL_W-1:0]   LAST_COL = COL_W'(GLYPH_W - 1);
  localparam logic [ROW_W-1:0]   LAST_ROW = ROW_W'(GLYPH_H - 1);
  localparam logic [COORD_W:0]   CLIP_X   = (COORD_W+1)'(SCREEN_W);
  localparam logic [COORD_W:0]   CLIP_Y   = (COORD_W+1)'(SCREEN_H);

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_LOAD, S_DRAW, S_DONE} state_t;

  state_t                  state_q;
  logic [CODE_W-1:0]       code_q;
  logic [COORD_W-1:0]      org_x_q, org_y_q;
  logic [COLOUR_W-1:0]     fg_q, bg_q;
  logic                    opaque_q;
  logic [ROW_W-1:0]        row_q;
  logic [COL_W-1:0]        col_q;
  logic [GLYPH_W-1:0]      bits_q;
  logic                    busy_q, done_q, plot_q;
  logic [COORD_W-1:0]      out_x_q, out_y_q;
  logic [COLOUR_W-1:0]     out_colour_q;
  logic [CODE_W+ROW_W-1:0] rom_addr_q;

  logic [COL_W-1:0]        cell_col_d;
  logic [GLYPH_W-1:0]      cell_bits_d;
  logic [COORD_W:0]        sx_d, sy_d;
  logic                    cell_set_d, plot_d, advance;
  logic [COLOUR_W-1:0]     out_colour_d;

  assign bus_if.busy       = busy_q;
  assign bus_if.done       = done_q;
  assign bus_if.plot       = plot_q;
  assign bus_if.out_x      = out_x_q;
  assign bus_if.out_y      = out_y_q;
  assign bus_if.out_colour = out_colour_q;
  assign bus_if.rom_addr   = rom_addr_q;

  // Evaluate the cell about to be presented, so plot/out_* leave the FSM already registered.
  always_comb begin
    cell_col_d   = (state_q == S_LOAD) ? '0 : col_q + 1'b1;
    cell_bits_d  = (state_q == S_LOAD) ? bus_if.rom_data : bits_q;
    sx_d         = {1'b0, org_x_q} + (COORD_W+1)'(cell_col_d);
    sy_d         = {1'b0, org_y_q} + (COORD_W+1)'(row_q);
    cell_set_d   = cell_bits_d[cell_col_d];
    plot_d       = (sx_d < CLIP_X) && (sy_d < CLIP_Y) && (cell_set_d || opaque_q);
    out_colour_d = cell_set_d ? fg_q : bg_q;
    advance      = !plot_q || bus_if.pixel_ready;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q      <= S_IDLE;
      code_q       <= '0;
      org_x_q      <= '0;
      org_y_q      <= '0;
      fg_q         <= '0;
      bg_q         <= '0;
      opaque_q     <= 1'b0;
      row_q        <= '0;
      col_q        <= '0;
      bits_q       <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      plot_q       <= 1'b0;
      out_x_q      <= '0;
      out_y_q      <= '0;
      out_colour_q <= '0;
      rom_addr_q   <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus_if.start) begin
            code_q     <= bus_if.char_code;
            org_x_q    <= bus_if.org_x;
            org_y_q    <= bus_if.org_y;
            fg_q       <= bus_if.fg_colour;
            bg_q       <= bus_if.bg_colour;
            opaque_q   <= bus_if.opaque;
            row_q      <= '0;
            col_q      <= '0;
            rom_addr_q <= {bus_if.char_code, {ROW_W{1'b0}}};
            busy_q     <= 1'b1;
            state_q    <= S_FETCH;
          end
        end
        S_FETCH: state_q <= S_LOAD;
        S_LOAD: begin
          bits_q       <= bus_if.rom_data;
          col_q        <= '0;
          plot_q       <= plot_d;
          out_x_q      <= sx_d[COORD_W-1:0];
          out_y_q      <= sy_d[COORD_W-1:0];
          out_colour_q <= out_colour_d;
          state_q      <= S_DRAW;
        end
        S_DRAW: begin
          if (advance) begin
            if (col_q != LAST_COL) begin
              col_q        <= cell_col_d;
              plot_q       <= plot_d;
              out_x_q      <= sx_d[COORD_W-1:0];
              out_y_q      <= sy_d[COORD_W-1:0];
              out_colour_q <= out_colour_d;
            end else begin
              plot_q <= 1'b0;
              if (row_q != LAST_ROW) begin
                row_q      <= row_q + 1'b1;
                rom_addr_q <= {code_q, row_q + 1'b1};
                state_q    <= S_FETCH;
              end else begin
                done_q  <= 1'b1;
                state_q <= S_DONE;
              end
            end
          end
        end
        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end
endmodule

// File: doc/char_blitter.md
# char_blitter

Parametrised glyph renderer. On a start request it reads one glyph bitmap row at a time from an external glyph ROM and emits one pixel write per glyph cell to the VGA adapter's plot port, at a caller-supplied origin and colour. Off-screen cells are clipped, and the plot port can apply back-pressure. It replaces the per-character combinational lookup blocks: any number of glyphs can share a single ROM and a single writer.

## Interface
- GLYPH_W, 10, glyph width in pixels (columns)
- GLYPH_H, 10, glyph height in pixels (rows)
- CODE_W, 6, width of the character code
- ROW_W, 4, width of the row index; must satisfy 2^ROW_W >= GLYPH_H
- COORD_W, 8, width of the x and y coordinates
- COLOUR_W, 6, colour width
- SCREEN_W, 160, clip limit in x; only x < SCREEN_W is drawn
- SCREEN_H, 120, clip limit in y; only y < SCREEN_H is drawn

Ports:
- clock  in  1  single clock, rising edge
- resetn  in  1  asynchronous, active-low reset
- start  in  1  request a draw; sampled only in IDLE
- char_code  in  CODE_W  glyph index
- org_x, org_y  in  COORD_W each  top-left corner of the glyph
- fg_colour, bg_colour  in  COLOUR_W each  colour for set cells / clear cells
- opaque  in  1  1 = clear cells are drawn in bg_colour; 0 = clear cells are skipped
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle pulse on completion
- rom_addr  out  CODE_W+ROW_W  {code_q, row}
- rom_data  in  GLYPH_W  row bitmap; bit c = column c (bit 0 = leftmost); valid 1 cycle after rom_addr
- out_x, out_y  out  COORD_W each  pixel coordinate
- out_colour  out  COLOUR_W  pixel colour
- plot  out  1  pixel write valid
- pixel_ready  in  1  plot port accepts the pixel this cycle

## Operation
- **IDLE:** busy=0, plot=0. On start=1:
  - latch char_code, org_x, org_y, fg_colour, bg_colour and opaque into *_q registers;
  - set row=0;
  - go to FETCH.
- **FETCH:** rom_addr={code_q,row}. Lasts 1 cycle; go to LOAD.
- **LOAD:** capture rom_data into bits_q; set col=0; go to DRAW.
- **DRAW:** handles one cell per visit.
  - Coordinates are computed with COORD_W+1-bit sums: sx=org_x_q+col, sy=org_y_q+row.
  - A cell is visible when sx<SCREEN_W and sy<SCREEN_H.
  - A cell is drawable when it is visible and (bits_q[col]=1 or opaque_q=1).
  - Drawable cell:
    - plot=1, out_x=sx[COORD_W-1:0], out_y=sy[COORD_W-1:0];
    - out_colour=fg_colour_q if the bit is set, else bg_colour_q;
    - advance only when pixel_ready=1, otherwise hold all outputs stable.
  - Non-drawable cell: plot=0; advance in 1 cycle regardless of pixel_ready.
  - Advance rules:
    - col<GLYPH_W-1: col+1, stay in DRAW;
    - col=GLYPH_W-1 and row<GLYPH_H-1: row+1, go to FETCH;
    - otherwise go to DONE.
- **DONE:** done=1 and busy=1 for 1 cycle, then go to IDLE.
- start while busy=1 is ignored; the latched inputs are not disturbed.
- Input changes after acceptance have no effect until the next accepted start.
- No wrap-around drawing: coordinates that overflow COORD_W fail the clip test.

## Timing
- Reset (asynchronous, any state):
  - state=IDLE;
  - busy, done and plot = 0;
  - out_x, out_y, out_colour, rom_addr = 0;
  - all internal counters and *_q registers = 0.
- Reset mid-draw abandons the glyph: no further plots and no done pulse.
- Start is accepted on clock edge E; busy rises after E.
- With no stalls (pixel_ready=1 throughout):
  - each row takes 2+GLYPH_W cycles;
  - done is high in cycle E+GLYPH_H*(2+GLYPH_W)+1 (E+121 for the defaults);
  - busy falls in the cycle after that.
- Each low cycle of pixel_ready during a drawable cell adds exactly 1 cycle.
- The earliest back-to-back start is sampled in the cycle after done, i.e. when IDLE is re-entered.
- plot, out_* and rom_addr are functions of registered state only; pixel_ready affects only the state advance.

## Test plan
- **Transparent 'A' glyph:** ROM rows (set columns per row) are {4,5}, {4,5}, {3,4,5,6}, {3,6}, {3,6}, {2,3,6,7}, {2..7}, {2,7}, {2,7}, {1,2,7,8}. Start with org=(0,0), opaque=0, pixel_ready=1 -> exactly 30 plots in fg_colour, first plot (4,0), last (8,9), done at E+121.
- **Same glyph, opaque=1, org=(20,30):** -> 100 plots in row-major order from (20,30) to (29,39); 30 in fg_colour and 70 in bg_colour; done at E+121.
- **Clipping, opaque=1:** org=(155,115) -> plots only for x 155..159 and y 115..119, i.e. 25 plots; done still at E+121.
- **Back-pressure:** pixel_ready low for 3 cycles on the first drawable cell -> plot/out_x/out_y/out_colour held stable for those cycles, no duplicate write, done at E+124.
- **Start while busy:** pulse start with different char_code mid-draw -> ignored; the original glyph completes and exactly one done pulse is seen.
- **Reset mid-draw:** assert resetn=0 in row 5 -> all outputs 0 immediately; after release, busy=0 and no done pulse; the next start draws correctly.
